// File: rtl/mfcc_pkg.sv
// mfcc_pkg: shared widths, Q15 constants and FSM states for the MFCC pipeline
package mfcc_pkg;
    localparam int POW_W = 32;
    localparam int WT_W = 16;
    localparam int BAND_W = 8;
    localparam int Q15_SHIFT = 15;
    localparam logic [16:0] Q15_ONE = 17'd32768;
    typedef enum logic [1:0] {ACCUM, FLUSH, DRAIN} state_t;
endpackage

// File: rtl/mel_weight_mac.sv
// mel_weight_mac: two-stage registered rising/falling Q15 weighting of a bin power
module mel_weight_mac
    import mfcc_pkg::*;
#(
    parameter int TAG_W = 9
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [POW_W-1:0] p,
    input  logic [WT_W-1:0]  w,
    input  logic [TAG_W-1:0] tag_in,
    output logic [47:0]      r,
    output logic [47:0]      f,
    output logic [TAG_W-1:0] tag_out
);
    logic [POW_W-1:0] p1;
    logic [WT_W-1:0]  w1;
    logic [TAG_W-1:0] t1;
    always_ff @(posedge clk) begin
        if (rst) begin
            p1 <= '0;
            w1 <= '0;
            t1 <= '0;
            r <= '0;
            f <= '0;
            tag_out <= '0;
        end else begin
            p1 <= p;
            w1 <= w;
            t1 <= tag_in;
            r <= 48'(p1) * 48'(w1);
            f <= 48'(p1) * 48'(Q15_ONE - {1'b0, w1});
            tag_out <= t1;
        end
    end
endmodule

// File: rtl/mel_filterbank.sv
// mel_filterbank: triangular mel filterbank accumulating power bins and draining mel energies
module mel_filterbank
    import mfcc_pkg::*;
#(
    parameter int NUM_BINS = 256,
    parameter int NUM_MELS = 40,
    parameter int ACC_W = 48
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [POW_W-1:0]             dft_out,
    input  logic                         dft_valid,
    output logic                         dft_ready,
    input  logic [NUM_BINS*BAND_W-1:0]   fb_band,
    input  logic [NUM_BINS*WT_W-1:0]     fb_wt,
    output logic [31:0]                  mel_out,
    output logic [7:0]                   mel_idx,
    output logic                         mel_valid,
    output logic                         mel_last,
    input  logic                         mel_ready,
    output logic                         overrun
);
    localparam int CW = $clog2(NUM_BINS);
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic [1:0] fl;
    logic [ACC_W-1:0] acc [NUM_MELS];
    logic [47:0] r, f;
    logic [BAND_W:0] t2;
    logic v2;
    logic [BAND_W-1:0] b2;
    logic accept, xfer;
    logic [7:0] nidx;
    logic [ACC_W-1:0] sel, sh;
    logic [31:0] nout;
    assign dft_ready = state == ACCUM;
    assign accept = dft_ready & dft_valid;
    assign xfer = mel_valid & mel_ready;
    assign v2 = t2[BAND_W];
    assign b2 = t2[BAND_W-1:0];
    mel_weight_mac #(.TAG_W(BAND_W + 1)) u_mac (
        .clk(clk),
        .rst(rst),
        .p(dft_out),
        .w(fb_wt[cnt*WT_W +: WT_W]),
        .tag_in({accept, fb_band[cnt*BAND_W +: BAND_W]}),
        .r(r),
        .f(f),
        .tag_out(t2)
    );
    function automatic logic [ACC_W-1:0] sat_add(input logic [ACC_W-1:0] a, input logic [47:0] x);
        logic [ACC_W:0] s;
        s = {1'b0, a} + (ACC_W + 1)'(x);
        return s[ACC_W] ? '1 : s[ACC_W-1:0];
    endfunction
    always_comb begin
        state_n = state == ACCUM ? ((accept && cnt == CW'(NUM_BINS - 1)) ? FLUSH : ACCUM) :
                  state == FLUSH ? (fl == 2'd2 ? DRAIN : FLUSH) :
                  ((xfer && mel_last) ? ACCUM : DRAIN);
    end
    // next filter to present: 0 on drain entry, otherwise the one after the current transfer
    always_comb begin
        nidx = mel_valid ? mel_idx + 8'd1 : 8'd0;
        sel = '0;
        for (int m = 0; m < NUM_MELS; m++)
            if (nidx == 8'(m)) sel = acc[m];
        sh = sel >> Q15_SHIFT;
        nout = |sh[ACC_W-1:32] ? '1 : sh[31:0];
    end
    always_ff @(posedge clk) begin
        if (rst) state <= ACCUM;
        else state <= state_n;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
            fl <= '0;
            overrun <= 1'b0;
        end else begin
            if (accept) cnt <= cnt + 1'b1;
            if (xfer && mel_last) cnt <= '0;
            fl <= state == FLUSH ? fl + 2'd1 : 2'd0;
            if (dft_valid && !dft_ready) overrun <= 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            mel_valid <= 1'b0;
            mel_out <= '0;
            mel_idx <= '0;
            mel_last <= 1'b0;
        end else if (state == DRAIN && (!mel_valid || xfer)) begin
            if (xfer && mel_last) begin
                mel_valid <= 1'b0;
                mel_last <= 1'b0;
            end else begin
                mel_valid <= 1'b1;
                mel_out <= nout;
                mel_idx <= nidx;
                mel_last <= nidx == 8'(NUM_MELS - 1);
            end
        end
    end
    // rising term lands on filter b2, falling term on b2-1; never the same filter
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int m = 0; m < NUM_MELS; m++) acc[m] <= '0;
        end else begin
            for (int m = 0; m < NUM_MELS; m++) begin
                if (xfer && mel_idx == 8'(m)) acc[m] <= '0;
                else if (v2 && b2 == BAND_W'(m)) acc[m] <= sat_add(acc[m], r);
                else if (v2 && b2 == BAND_W'(m + 1)) acc[m] <= sat_add(acc[m], f);
            end
        end
    end
endmodule

// File: tb/tb_mel_filterbank.sv
// tb_mel_filterbank: directed frame vectors plus overrun, mid-frame reset and back-to-back checks
module tb_mel_filterbank;
    logic clk = 0, rst = 1;
    logic [31:0] dft_out = '0;
    logic dft_valid = 0, dft_ready;
    logic [63:0] fb_band = '0;
    logic [127:0] fb_wt = '0;
    logic [31:0] mel_out;
    logic [7:0] mel_idx;
    logic mel_valid, mel_last, mel_ready = 0, overrun;
    int checks = 0, errors = 0;
    typedef struct {
        logic [7:0][31:0] p;
        logic [7:0][7:0]  b;
        logic [7:0][15:0] w;
        logic [2:0][31:0] e;
        bit rnd;
    } vec_t;
    vec_t tv[4];
    always #5 clk = ~clk;
    mel_filterbank #(.NUM_BINS(8), .NUM_MELS(3), .ACC_W(48)) dut (
        .clk(clk), .rst(rst), .dft_out(dft_out), .dft_valid(dft_valid), .dft_ready(dft_ready),
        .fb_band(fb_band), .fb_wt(fb_wt), .mel_out(mel_out), .mel_idx(mel_idx),
        .mel_valid(mel_valid), .mel_last(mel_last), .mel_ready(mel_ready), .overrun(overrun)
    );
    task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", n, a, e, $time);
        end
    endtask
    task automatic load(input vec_t v);
        fb_band = v.b;
        fb_wt = v.w;
    endtask
    task automatic send(input logic [7:0][31:0] p, input int n);
        for (int k = 0; k < n; k++) begin
            dft_valid = 1;
            dft_out = p[k];
            chk("ready_accum", 64'(dft_ready), 1);
            @(negedge clk);
        end
        dft_valid = 0;
        dft_out = '0;
        if (n == 8) chk("ready_drop_after_last_bin", 64'(dft_ready), 0);
    endtask
    task automatic drain(input logic [2:0][31:0] e, input bit rnd);
        int got = 0, cyc = 0;
        logic held = 0, hl = 0;
        logic [31:0] ho = '0;
        logic [7:0] hi = '0;
        while (got < 3 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            chk("ready_low_drain", 64'(dft_ready), 0);
            if (held) begin
                chk("hold_valid", 64'(mel_valid), 1);
                chk("hold_out", 64'(mel_out), 64'(ho));
                chk("hold_idx", 64'(mel_idx), 64'(hi));
                chk("hold_last", 64'(mel_last), 64'(hl));
            end
            mel_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (mel_valid && mel_ready) begin
                chk("mel_idx", 64'(mel_idx), 64'(got));
                chk("mel_out", 64'(mel_out), 64'(e[got]));
                chk("mel_last", 64'(mel_last), 64'(got == 2));
                got++;
                held = 0;
            end else begin
                held = mel_valid;
                ho = mel_out;
                hi = mel_idx;
                hl = mel_last;
            end
        end
        if (got < 3) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout got %0d transfers want 3", got);
        end
        mel_ready = 1;
        @(negedge clk);
        chk("valid_after_last", 64'(mel_valid), 0);
        chk("last_after_last", 64'(mel_last), 0);
        chk("ready_after_last", 64'(dft_ready), 1);
    endtask
    initial begin
        #300000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        tv[0].p = '0; tv[0].b = '0; tv[0].w = '0;
        tv[0].p[2] = 1000; tv[0].b[2] = 1; tv[0].w[2] = 16384;
        tv[0].e[0] = 500; tv[0].e[1] = 500; tv[0].e[2] = 0; tv[0].rnd = 0;
        for (int k = 0; k < 8; k++) begin
            tv[1].p[k] = 32'hFFFF_FFFF; tv[1].b[k] = 1; tv[1].w[k] = 16'd32768;
        end
        tv[1].e[0] = 0; tv[1].e[1] = 32'hFFFF_FFFF; tv[1].e[2] = 0; tv[1].rnd = 0;
        tv[2].p = '0; tv[2].b = '0; tv[2].w = '0;
        tv[2].p[0] = 100; tv[2].b[0] = 0; tv[2].w[0] = 16'd32768;
        tv[2].p[1] = 200; tv[2].b[1] = 3; tv[2].w[1] = 0;
        tv[2].p[3] = 64;  tv[2].b[3] = 2; tv[2].w[3] = 8192;
        tv[2].p[5] = 1;   tv[2].b[5] = 1; tv[2].w[5] = 16'd32768;
        tv[2].p[6] = 3;   tv[2].b[6] = 2; tv[2].w[6] = 16384;
        tv[2].e[0] = 100; tv[2].e[1] = 50; tv[2].e[2] = 217; tv[2].rnd = 1;
        for (int k = 0; k < 8; k++) begin
            tv[3].p[k] = 5000; tv[3].b[k] = 0; tv[3].w[k] = 0;
        end
        tv[3].p[4] = 7;     tv[3].w[4] = 16'd32768;
        tv[3].p[7] = 32768; tv[3].b[7] = 3; tv[3].w[7] = 16'd32768;
        tv[3].e[0] = 7; tv[3].e[1] = 0; tv[3].e[2] = 0; tv[3].rnd = 0;
        repeat (3) @(negedge clk);
        chk("rst_mel_out", 64'(mel_out), 0);
        chk("rst_mel_idx", 64'(mel_idx), 0);
        chk("rst_mel_valid", 64'(mel_valid), 0);
        chk("rst_mel_last", 64'(mel_last), 0);
        chk("rst_overrun", 64'(overrun), 0);
        chk("rst_dft_ready", 64'(dft_ready), 1);
        rst = 0;
        for (int i = 0; i < 4; i++) begin
            load(tv[i]);
            send(tv[i].p, 8);
            drain(tv[i].e, tv[i].rnd);
        end
        load(tv[0]);
        send(tv[0].p, 8);
        mel_ready = 0;
        for (int c = 0; c < 20 && !mel_valid; c++) @(negedge clk);
        chk("valid_before_drop", 64'(mel_valid), 1);
        chk("overrun_before_drop", 64'(overrun), 0);
        dft_valid = 1;
        dft_out = 32'hFFFF_FFFF;
        @(negedge clk);
        dft_valid = 0;
        dft_out = '0;
        @(negedge clk);
        chk("overrun_set", 64'(overrun), 1);
        drain(tv[0].e, 0);
        send(tv[0].p, 8);
        drain(tv[0].e, 1);
        chk("overrun_sticky", 64'(overrun), 1);
        load(tv[2]);
        send(tv[2].p, 4);
        rst = 1;
        @(negedge clk);
        rst = 0;
        chk("midrst_overrun", 64'(overrun), 0);
        chk("midrst_ready", 64'(dft_ready), 1);
        chk("midrst_valid", 64'(mel_valid), 0);
        load(tv[3]);
        send(tv[3].p, 8);
        drain(tv[3].e, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
